// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounces three pushbuttons and sequences the
// IDLE / RUN / PAUSED states, lap captures and display source selection.
//
// Ports:
//   clk_50M    system clock, all logic on its rising edge
//   reset_n    asynchronous active-low reset
//   btn_start  raw start/stop button (asynchronous, active-high)
//   btn_lap    raw lap button (asynchronous, active-high)
//   btn_clear  raw clear button (asynchronous, active-high)
//   run        time-counter enable, 1 exactly while state = RUN
//   clr        one-cycle clear pulse for time counter and lap registers
//   lap_we     one-cycle lap capture strobe
//   lap_slot   lap register targeted by lap_we (1..3), 0 otherwise
//   view_sel   display source: 0 live time, 1..3 lap register
//   laps_used  number of stored laps (0..3)
//   state      FSM state: 0 IDLE, 1 RUN, 2 PAUSED
module stopwatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk_50M,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       run,
    output logic       clr,
    output logic       lap_we,
    output logic [1:0] lap_slot,
    output logic [1:0] view_sel,
    output logic [1:0] laps_used,
    output logic [1:0] state
);

    localparam int unsigned CNT_W     = 20;
    localparam int unsigned NUM_BTN   = 3;
    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_LAP   = 1;
    localparam int unsigned BTN_CLEAR = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       LAPS_MAX = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] deb;
    logic [NUM_BTN-1:0] deb_d;
    logic [CNT_W-1:0]   cnt [NUM_BTN];
    logic [NUM_BTN-1:0] press_c;

    logic ev_clear_c;
    logic ev_start_c;
    logic ev_lap_c;

    state_t     state_q;
    state_t     state_nxt;
    logic       clr_nxt;
    logic       lap_we_nxt;
    logic [1:0] lap_slot_nxt;
    logic [1:0] view_sel_nxt;
    logic [1:0] laps_used_nxt;
    logic [1:0] view_adv_c;

    assign raw = {btn_clear, btn_lap, btn_start};

    // Two-flop synchronizers for the asynchronous buttons
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-button debounce: level is accepted after DEBOUNCE_CYCLES stable cycles
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising edge of a debounced level is a press; release is ignored
    assign press_c = deb & ~deb_d;

    // Only the highest-priority press of a cycle survives: clear > start > lap
    assign ev_clear_c = press_c[BTN_CLEAR];
    assign ev_start_c = press_c[BTN_START] & ~press_c[BTN_CLEAR];
    assign ev_lap_c   = press_c[BTN_LAP] & ~press_c[BTN_START] & ~press_c[BTN_CLEAR];

    // Next display source when browsing laps: wraps back to live time
    assign view_adv_c = (laps_used == 2'd0 || view_sel == laps_used) ? 2'd0
                                                                     : view_sel + 2'd1;

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state_q;
        clr_nxt       = 1'b0;
        lap_we_nxt    = 1'b0;
        lap_slot_nxt  = 2'd0;
        view_sel_nxt  = view_sel;
        laps_used_nxt = laps_used;

        case (state_q)
            ST_IDLE, ST_PAUSED: begin
                if (ev_clear_c) begin
                    state_nxt     = ST_IDLE;
                    clr_nxt       = 1'b1;
                    laps_used_nxt = 2'd0;
                    view_sel_nxt  = 2'd0;
                end else if (ev_start_c) begin
                    state_nxt    = ST_RUN;
                    view_sel_nxt = 2'd0;
                end else if (ev_lap_c) begin
                    view_sel_nxt = view_adv_c;
                end
            end
            ST_RUN: begin
                // A clear press in RUN is consumed without effect
                if (ev_start_c) begin
                    state_nxt = ST_PAUSED;
                end else if (ev_lap_c && laps_used != LAPS_MAX) begin
                    lap_we_nxt    = 1'b1;
                    lap_slot_nxt  = laps_used + 2'd1;
                    laps_used_nxt = laps_used + 2'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            run       <= 1'b0;
            clr       <= 1'b0;
            lap_we    <= 1'b0;
            lap_slot  <= 2'd0;
            view_sel  <= 2'd0;
            laps_used <= 2'd0;
        end else begin
            state_q   <= state_nxt;
            run       <= (state_nxt == ST_RUN);
            clr       <= clr_nxt;
            lap_we    <= lap_we_nxt;
            lap_slot  <= lap_slot_nxt;
            view_sel  <= view_sel_nxt;
            laps_used <= laps_used_nxt;
        end
    end

    assign state = state_q;

endmodule
